// File: rtl/daq_pattern_pkg.sv
// Shared encodings and sample-formatting helpers for the DAQ pattern generator.
package daq_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_CNT   = 2'b00,
        MODE_WALK  = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_CONST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        WSEL_8   = 2'b00,
        WSEL_16  = 2'b01,
        WSEL_32  = 2'b10,
        WSEL_32B = 2'b11
    } wsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;

    function automatic logic [31:0] width_mask(input logic [1:0] wsel);
        case (wsel_e'(wsel))
            WSEL_8:  width_mask = 32'h0000_00FF;
            WSEL_16: width_mask = 32'h0000_FFFF;
            default: width_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Right-shifting Galois step: the bit shifted out selects the polynomial XOR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] poly);
        lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? poly : 32'h0);
    endfunction

    // idx is seed + k for the sample being formed.
    function automatic logic [31:0] make_sample(input mode_e m, input logic [1:0] wsel,
                                                input logic [31:0] idx, input logic [31:0] lfsr,
                                                input logic [31:0] seed);
        logic [4:0] bit_pos;
        case (wsel_e'(wsel))
            WSEL_8:  bit_pos = {2'b00, idx[2:0]};
            WSEL_16: bit_pos = {1'b0, idx[3:0]};
            default: bit_pos = idx[4:0];
        endcase
        case (m)
            MODE_CNT:  make_sample = idx & width_mask(wsel);
            MODE_WALK: make_sample = 32'h1 << bit_pos;
            MODE_LFSR: make_sample = lfsr & width_mask(wsel);
            default:   make_sample = seed & width_mask(wsel);
        endcase
    endfunction

endpackage

// File: rtl/daq_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
module daq_lfsr32
    import daq_pattern_pkg::*;
#(
    parameter logic [31:0] POLY = LFSR_POLY_DEFAULT
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        advance,
    output logic [31:0] state,
    output logic [31:0] next_state
);

    assign next_state = lfsr_step(state, POLY);

    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            state <= 32'h1;
        else if (load)
            state <= load_val;
        else if (advance)
            state <= next_state;
    end

endmodule

// File: rtl/daq_pattern_gen.sv
// Test-pattern source: emits NUM_SAMPLES samples per start with valid/ready handshake.
// Build option DAQ_PATTERN_GAP_EN inserts one idle cycle after every transfer.
module daq_pattern_gen
    import daq_pattern_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 16,
    parameter logic [31:0] LFSR_POLY   = LFSR_POLY_DEFAULT
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [1:0]  width_sel,
    input  logic [31:0] seed,
    input  logic        sink_ready,
    output logic [31:0] adc_data_out,
    output logic        adc_data_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] sample_count
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

    state_e      st;
    mode_e       mode_q;
    logic [1:0]  wsel_q;
    logic [31:0] seed_q;
    logic [31:0] idx_q;
    logic [31:0] seed_nz;
    logic [31:0] lfsr_state;
    logic [31:0] lfsr_next;
    logic        launch;
    logic        xfer;
    logic        last;

    assign seed_nz = (seed == 32'h0) ? 32'h1 : seed;
    assign launch  = (st == ST_IDLE) && start;
    assign xfer    = (st == ST_RUN) && adc_data_ready && sink_ready;
    assign last    = (sample_count == LAST_IDX);

    daq_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .load       (launch),
        .load_val   (seed_nz),
        .advance    (xfer),
        .state      (lfsr_state),
        .next_state (lfsr_next)
    );

`ifdef DAQ_PATTERN_GAP_EN
    logic gap_q;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            st             <= ST_IDLE;
            mode_q         <= MODE_CNT;
            wsel_q         <= 2'b00;
            seed_q         <= 32'h0;
            idx_q          <= 32'h0;
            adc_data_out   <= 32'h0;
            adc_data_ready <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sample_count   <= 16'h0;
`ifdef DAQ_PATTERN_GAP_EN
            gap_q          <= 1'b0;
`endif
        end else begin
            case (st)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q         <= mode_e'(mode);
                        wsel_q         <= width_sel;
                        seed_q         <= seed;
                        idx_q          <= seed;
                        sample_count   <= 16'h0;
                        adc_data_out   <= make_sample(mode_e'(mode), width_sel, seed, seed_nz, seed);
                        adc_data_ready <= 1'b1;
                        busy           <= 1'b1;
                        st             <= ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef DAQ_PATTERN_GAP_EN
                    if (gap_q) begin
                        gap_q          <= 1'b0;
                        adc_data_ready <= 1'b1;
                    end
`endif
                    if (xfer) begin
                        sample_count <= sample_count + 16'd1;
                        if (last) begin
                            adc_data_ready <= 1'b0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            st             <= ST_DONE;
                        end else begin
                            // Next sample is formed now so it is ready the cycle after the transfer.
                            idx_q        <= idx_q + 32'd1;
                            adc_data_out <= make_sample(mode_q, wsel_q, idx_q + 32'd1, lfsr_next, seed_q);
`ifdef DAQ_PATTERN_GAP_EN
                            adc_data_ready <= 1'b0;
                            gap_q          <= 1'b1;
`endif
                        end
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    st   <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
